seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 104 ++++++++++
 tb/tb_seg7_scan_driver.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: eight-digit time-multiplexed common-anode seven-segment
// driver. A scan-rate divider advances a 3-bit digit index. Registered SEG/DIG
// outputs update together on every edge, so digit and segments never skew.
module seg7_scan_driver #(
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] num0,
   input  logic [3:0] num1,
   input  logic [3:0] num2,
   input  logic [3:0] num3,
   input  logic [3:0] num4,
   input  logic [3:0] num5,
   input  logic [3:0] num6,
   input  logic [3:0] num7,
   output logic [7:0] SEG,
   output logic [7:0] DIG
);

   localparam int unsigned    CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] div_cnt;
   logic             scan_tick;
   logic [2:0]       idx;
   logic [3:0]       cur_num;
   logic [7:0]       cur_seg;

   // Active-low segment pattern {dp,g,f,e,d,c,b,a}; dp is always off.
   function automatic logic [7:0] decode(input logic [3:0] v);
      logic [7:0] s;
      case (v)
         4'h0:    s = 8'hC0;
         4'h1:    s = 8'hF9;
         4'h2:    s = 8'hA4;
         4'h3:    s = 8'hB0;
         4'h4:    s = 8'h99;
         4'h5:    s = 8'h92;
         4'h6:    s = 8'h82;
         4'h7:    s = 8'hF8;
         4'h8:    s = 8'h80;
         4'h9:    s = 8'h90;
         4'hA:    s = 8'h88;
         4'hB:    s = 8'h83;
         4'hC:    s = 8'hC6;
         4'hD:    s = 8'hA1;
         4'hE:    s = 8'h86;
         default: s = 8'h8E;
      endcase
      return s;
   endfunction

   // Terminal count of the divider; with SCAN_DIV=1 this is true every cycle.
   assign scan_tick = (div_cnt == CNT_MAX);

   // Scan-rate divider: counts 0..SCAN_DIV-1 and wraps.
   always_ff @(posedge clk) begin
      if (!rst) begin
         div_cnt <= '0;
      end else if (scan_tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + CNT_W'(1);
      end
   end

   // Digit index advances once per scan tick and wraps 7 -> 0 naturally.
   always_ff @(posedge clk) begin
      if (!rst) begin
         idx <= '0;
      end else if (scan_tick) begin
         idx <= idx + 3'd1;
      end
   end

   // Select the live input for the digit currently being scanned.
   always_comb begin
      cur_num = num0;
      case (idx)
         3'd0:    cur_num = num0;
         3'd1:    cur_num = num1;
         3'd2:    cur_num = num2;
         3'd3:    cur_num = num3;
         3'd4:    cur_num = num4;
         3'd5:    cur_num = num5;
         3'd6:    cur_num = num6;
         default: cur_num = num7;
      endcase
      cur_seg = decode(cur_num);
   end

   // Output register: SEG and DIG change on the same edge; dark in reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         SEG <= '1;
         DIG <= '1;
      end else begin
         SEG <= cur_seg;
         DIG <= ~(8'b1 << idx);
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver: two instances (SCAN_DIV=4 and SCAN_DIV=1)
// share stimulus; a model predicts each edge's outputs into a queue and a
// monitor pops and compares on the falling edge.
module tb_seg7_scan_driver;

   logic       clk;
   logic       rst;
   logic [3:0] num [8];
   logic [7:0] seg4, dig4, seg1, dig1;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] seg4;
      logic [7:0] dig4;
      logic [7:0] seg1;
      logic [7:0] dig1;
      bit         active;
   } exp_t;

   exp_t sb[$];

   logic [7:0] seg_table [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   seg7_scan_driver #(.SCAN_DIV(4)) dut4 (
      .clk(clk), .rst(rst),
      .num0(num[0]), .num1(num[1]), .num2(num[2]), .num3(num[3]),
      .num4(num[4]), .num5(num[5]), .num6(num[6]), .num7(num[7]),
      .SEG(seg4), .DIG(dig4)
   );

   seg7_scan_driver #(.SCAN_DIV(1)) dut1 (
      .clk(clk), .rst(rst),
      .num0(num[0]), .num1(num[1]), .num2(num[2]), .num3(num[3]),
      .num4(num[4]), .num5(num[5]), .num6(num[6]), .num7(num[7]),
      .SEG(seg1), .DIG(dig1)
   );

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: after release, edge n (1-based) shows digit
   // floor((n-1)/SCAN_DIV) mod 8 with the input value present at that edge.
   initial begin
      int unsigned n;
      int unsigned d4, d1;
      exp_t e;
      n = 0;
      forever begin
         @(posedge clk);
         if (rst !== 1'b1) begin
            n = 0;
            e.seg4 = 8'hFF; e.dig4 = 8'hFF;
            e.seg1 = 8'hFF; e.dig1 = 8'hFF;
            e.active = 1'b0;
         end else begin
            n++;
            d4 = ((n - 1) / 4) % 8;
            d1 = (n - 1) % 8;
            e.seg4 = seg_table[num[d4]];
            e.dig4 = 8'hFF ^ (8'd1 << d4);
            e.seg1 = seg_table[num[d1]];
            e.dig1 = 8'hFF ^ (8'd1 << d1);
            e.active = 1'b1;
         end
         sb.push_back(e);
      end
   end

   // Monitor: compare DUT outputs with the predicted values away from the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("seg_div4", seg4, e.seg4);
            check("dig_div4", dig4, e.dig4);
            check("seg_div1", seg1, e.seg1);
            check("dig_div1", dig1, e.dig1);
            check("dp_off_div4", {7'd0, seg4[7]}, 8'd1);
            if (e.active) begin
               check("onehot_div4", 8'($countones(~dig4)), 8'd1);
               check("onehot_div1", 8'($countones(~dig1)), 8'd1);
            end
         end
      end
   end

   task automatic cycles(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic rand_nums();
      for (int i = 0; i < 8; i++) num[i] = 4'($urandom_range(0, 15));
   endtask

   // Stimulus.
   initial begin
      rst = 1'b0;
      rand_nums();
      // Reset hold with random inputs.
      for (int c = 0; c < 5; c++) begin
         cycles(1);
         rand_nums();
      end
      // Scan order / dwell / wrap with num = 0..7.
      for (int i = 0; i < 8; i++) num[i] = 4'(i);
      rst = 1'b1;
      cycles(70);
      // Decode sweep on digit 0: reset, release, hold value through first dwell.
      for (int v = 0; v < 16; v++) begin
         rst = 1'b0;
         cycles(1);
         num[0] = 4'(v);
         rst = 1'b1;
         cycles(4);
      end
      // Live update of digit 3 mid-dwell (digit 3 occupies edges 13..16).
      rst = 1'b0;
      num[3] = 4'd5;
      cycles(1);
      rst = 1'b1;
      cycles(14);
      num[3] = 4'd9;
      cycles(4);
      // Reset during digit-5 dwell (edges 21..24), then full restart.
      rst = 1'b0;
      cycles(1);
      rst = 1'b1;
      cycles(22);
      rst = 1'b0;
      cycles(1);
      rst = 1'b1;
      cycles(40);
      // Randomized inputs with occasional resets.
      for (int c = 0; c < 2000; c++) begin
         rand_nums();
         rst = ($urandom_range(0, 99) != 0);
         cycles(1);
      end
      rst = 1'b1;
      cycles(3);
      for (int k = 0; k < 10 && sb.size() > 1; k++) cycles(1);
      checks++;
      if (sb.size() > 1) begin
         failures++;
         $display("FAIL drain: queue depth %0d expected <=1", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog.
   initial begin
      #1_000_000;
      failures++;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
